writeback_queue: RTL and testbench

Write-side companion to the integer register file: collects destination-register results from the in-order pipeline and the long-latency multiply/divide unit, buffers them in a small FIFO, and serializes them onto the register file's single write port (wren/waddr/wdata). It sits between the writeback stage and the register file. While results are still pending, it also provides a forwarding lookup so the decode-stage readers see buffered values before they are committed.

---
 rtl/writeback_queue_if.sv | 51 +++++
 rtl/writeback_queue.sv | 129 ++++++++++++
 tb/tb_writeback_queue.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_queue_if.sv
// Bus bundle for writeback_queue: pipeline and mul/div result handshakes,
// the register-file write port, and the two decode-stage forwarding lookups.
interface writeback_queue_if #(
  parameter int XLEN = 32
);
  logic            pipe_valid;
  logic            pipe_ready;
  logic [4:0]      pipe_waddr;
  logic [XLEN-1:0] pipe_wdata;

  logic            mdu_valid;
  logic            mdu_ready;
  logic [4:0]      mdu_waddr;
  logic [XLEN-1:0] mdu_wdata;

  logic            wstall;
  logic            wren;
  logic [4:0]      waddr;
  logic [XLEN-1:0] wdata;

  logic [4:0]      fwd_addr1;
  logic [4:0]      fwd_addr2;
  logic            fwd_hit1;
  logic            fwd_hit2;
  logic [XLEN-1:0] fwd_data1;
  logic [XLEN-1:0] fwd_data2;

  // Queue side.
  modport slave (
    input  pipe_valid, pipe_waddr, pipe_wdata,
    output pipe_ready,
    input  mdu_valid, mdu_waddr, mdu_wdata,
    output mdu_ready,
    input  wstall,
    output wren, waddr, wdata,
    input  fwd_addr1, fwd_addr2,
    output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
  );

  // Producer / register-file side.
  modport master (
    output pipe_valid, pipe_waddr, pipe_wdata,
    input  pipe_ready,
    output mdu_valid, mdu_waddr, mdu_wdata,
    input  mdu_ready,
    output wstall,
    input  wren, waddr, wdata,
    output fwd_addr1, fwd_addr2,
    input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
  );
endinterface

// File: rtl/writeback_queue.sv
// Writeback queue: buffers pipeline / mul-div results and serializes them onto
// the register-file write port, with forwarding of pending values.
// Define WBQ_BYPASS_EN for a zero-latency path when the queue is empty.
module writeback_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input logic             clk,
  input logic             rst,
  writeback_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic   full;
  logic   empty;
  logic   pipe_fire;
  logic   mdu_fire;
  logic   acc;
  logic   bypass;
  logic   enq;
  logic   deq;
  entry_t acc_ent;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Ready ignores a same-cycle drain so it never depends on wstall.
  assign bus.pipe_ready = !rst && !full;
  assign bus.mdu_ready  = !rst && !full && !bus.pipe_valid;

  assign pipe_fire = bus.pipe_valid && bus.pipe_ready;
  assign mdu_fire  = bus.mdu_valid  && bus.mdu_ready;
  assign acc       = pipe_fire || mdu_fire;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    acc_ent.addr = bus.mdu_waddr;
    acc_ent.data = bus.mdu_wdata;
    if (pipe_fire) begin
      acc_ent.addr = bus.pipe_waddr;
      acc_ent.data = bus.pipe_wdata;
    end
  end

`ifdef WBQ_BYPASS_EN
  assign bypass = acc && (acc_ent.addr != 5'd0) && empty && !bus.wstall;
`else
  assign bypass = 1'b0;
`endif

  // Writes to x0 complete the handshake but are never stored.
  assign enq = acc && (acc_ent.addr != 5'd0) && !bypass;
  assign deq = !rst && !empty && !bus.wstall;

  always_comb begin
    bus.wren  = 1'b0;
    bus.waddr = 5'd0;
    bus.wdata = '0;
    if (deq) begin
      bus.wren  = 1'b1;
      bus.waddr = mem[head].addr;
      bus.wdata = mem[head].data;
    end else if (bypass) begin
      bus.wren  = 1'b1;
      bus.waddr = acc_ent.addr;
      bus.wdata = acc_ent.data;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PTR_W'(1);
      if (deq) head <= head + PTR_W'(1);
      unique case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: entry storage is not reset; count alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (enq) mem[tail] <= acc_ent;
  end

  // Walk live entries oldest to youngest so the last match (youngest) wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx           = head;
    bus.fwd_hit1  = 1'b0;
    bus.fwd_hit2  = 1'b0;
    bus.fwd_data1 = '0;
    bus.fwd_data2 = '0;
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + PTR_W'(i);
        if (CNT_W'(i) < count) begin
          if ((bus.fwd_addr1 != 5'd0) && (mem[idx].addr == bus.fwd_addr1)) begin
            bus.fwd_hit1  = 1'b1;
            bus.fwd_data1 = mem[idx].data;
          end
          if ((bus.fwd_addr2 != 5'd0) && (mem[idx].addr == bus.fwd_addr2)) begin
            bus.fwd_hit2  = 1'b1;
            bus.fwd_data2 = mem[idx].data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: directed scenarios followed by
// randomized traffic compared every cycle against a queue-based reference.
module tb_writeback_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  ent_t q[$];

  writeback_queue_if #(.XLEN(32)) bus();

  writeback_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.pipe_valid = 1'b0;
    bus.pipe_waddr = 5'd0;
    bus.pipe_wdata = 32'd0;
    bus.mdu_valid  = 1'b0;
    bus.mdu_waddr  = 5'd0;
    bus.mdu_wdata  = 32'd0;
    bus.wstall     = 1'b0;
    bus.fwd_addr1  = 5'd0;
    bus.fwd_addr2  = 5'd0;
  endtask

  task automatic set_pipe(input logic [4:0] a, input logic [31:0] d);
    bus.pipe_valid = 1'b1;
    bus.pipe_waddr = a;
    bus.pipe_wdata = d;
  endtask

  task automatic set_mdu(input logic [4:0] a, input logic [31:0] d);
    bus.mdu_valid = 1'b1;
    bus.mdu_waddr = a;
    bus.mdu_wdata = d;
  endtask

  // Youngest pending write to a nonzero register.
  function automatic void lookup(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = 32'd0;
    if (a != 5'd0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].addr == a) begin
          h = 1'b1;
          d = q[i].data;
          break;
        end
      end
    end
  endfunction

  // Compare every output with the reference, then clock and update it.
  task automatic cycle();
    logic        e_pr, e_mr, acc, byp, drain, e_wren, h1, h2;
    logic [4:0]  a_addr, e_waddr;
    logic [31:0] a_data, e_wdata, d1, d2;
    int          n;
    #1;
    n      = q.size();
    e_pr   = !rst && (n != DEPTH);
    e_mr   = e_pr && !bus.pipe_valid;
    acc    = 1'b0;
    a_addr = 5'd0;
    a_data = 32'd0;
    if (bus.pipe_valid && e_pr) begin
      acc = 1'b1; a_addr = bus.pipe_waddr; a_data = bus.pipe_wdata;
    end else if (bus.mdu_valid && e_mr) begin
      acc = 1'b1; a_addr = bus.mdu_waddr; a_data = bus.mdu_wdata;
    end
    drain = !rst && (n != 0) && !bus.wstall;
`ifdef WBQ_BYPASS_EN
    byp = acc && (a_addr != 5'd0) && (n == 0) && !bus.wstall;
`else
    byp = 1'b0;
`endif
    e_wren  = drain || byp;
    e_waddr = drain ? q[0].addr : (byp ? a_addr : 5'd0);
    e_wdata = drain ? q[0].data : (byp ? a_data : 32'd0);
    lookup(bus.fwd_addr1, h1, d1);
    lookup(bus.fwd_addr2, h2, d2);
    if (rst) begin
      h1 = 1'b0; d1 = 32'd0; h2 = 1'b0; d2 = 32'd0;
    end
    check("m_pipe_ready", bus.pipe_ready, e_pr);
    check("m_mdu_ready",  bus.mdu_ready,  e_mr);
    check("m_wren",       bus.wren,       e_wren);
    check("m_waddr",      bus.waddr,      e_waddr);
    check("m_wdata",      bus.wdata,      e_wdata);
    check("m_fwd_hit1",   bus.fwd_hit1,   h1);
    check("m_fwd_data1",  bus.fwd_data1,  d1);
    check("m_fwd_hit2",   bus.fwd_hit2,   h2);
    check("m_fwd_data2",  bus.fwd_data2,  d2);
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      if (drain) void'(q.pop_front());
      if (acc && (a_addr != 5'd0) && !byp) q.push_back('{a_addr, a_data});
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk);

    // Reset: nothing accepted, all outputs quiet.
    set_pipe(5'd2, 32'h22);
    bus.fwd_addr1 = 5'd2;
    #1;
    check("rst_pipe_ready", bus.pipe_ready, 1'b0);
    check("rst_mdu_ready",  bus.mdu_ready,  1'b0);
    check("rst_wren",       bus.wren,       1'b0);
    check("rst_fwd_hit1",   bus.fwd_hit1,   1'b0);
    cycle();
    cycle();
    rst = 1'b0;
    idle();

    // Single write x5 = 0x11.
    set_pipe(5'd5, 32'h11);
    #1;
    check("x5_ready", bus.pipe_ready, 1'b1);
`ifdef WBQ_BYPASS_EN
    check("x5_byp_wren",  bus.wren,  1'b1);
    check("x5_byp_waddr", bus.waddr, 5'd5);
`else
    check("x5_same_wren", bus.wren, 1'b0);
`endif
    cycle();
    idle();
    #1;
`ifdef WBQ_BYPASS_EN
    check("x5_after_wren", bus.wren, 1'b0);
`else
    check("x5_wren",  bus.wren,  1'b1);
    check("x5_waddr", bus.waddr, 5'd5);
    check("x5_wdata", bus.wdata, 32'h11);
`endif
    cycle();
    #1;
    check("x5_idle_wren",  bus.wren,  1'b0);
    check("x5_idle_waddr", bus.waddr, 5'd0);
    check("x5_idle_wdata", bus.wdata, 32'd0);
    cycle();

    // Fill under wstall, then drain in order.
    bus.wstall = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      set_pipe(5'(i), 32'h100 + 32'(i));
      #1;
      check("fill_ready", bus.pipe_ready, 1'b1);
      cycle();
    end
    set_pipe(5'd9, 32'h999);
    set_mdu(5'd10, 32'haaa);
    #1;
    check("full_pipe_ready", bus.pipe_ready, 1'b0);
    check("full_mdu_ready",  bus.mdu_ready,  1'b0);
    cycle();
    idle();
    for (int i = 1; i <= DEPTH; i++) begin
      #1;
      check("drain_wren",  bus.wren,  1'b1);
      check("drain_waddr", bus.waddr, 5'(i));
      check("drain_wdata", bus.wdata, 32'h100 + 32'(i));
      cycle();
    end
    #1;
    check("drained_wren", bus.wren, 1'b0);
    cycle();

    // Pipe has priority over mdu.
    bus.wstall = 1'b1;
    set_pipe(5'd3, 32'h33);
    set_mdu(5'd4, 32'h44);
    #1;
    check("prio_pipe_ready", bus.pipe_ready, 1'b1);
    check("prio_mdu_ready",  bus.mdu_ready,  1'b0);
    cycle();
    bus.pipe_valid = 1'b0;
    #1;
    check("prio_mdu_ready2", bus.mdu_ready, 1'b1);
    cycle();
    idle();
    #1;
    check("prio_first",  bus.waddr, 5'd3);
    cycle();
    #1;
    check("prio_second", bus.waddr, 5'd4);
    check("prio_sdata",  bus.wdata, 32'h44);
    cycle();

    // Same register twice: forwarding returns the youngest value.
    bus.wstall = 1'b1;
    set_pipe(5'd7, 32'hA);
    cycle();
    set_pipe(5'd7, 32'hB);
    cycle();
    idle();
    bus.wstall    = 1'b1;
    bus.fwd_addr1 = 5'd7;
    bus.fwd_addr2 = 5'd0;
    #1;
    check("fwd_hit1",  bus.fwd_hit1,  1'b1);
    check("fwd_data1", bus.fwd_data1, 32'hB);
    check("fwd_hit2",  bus.fwd_hit2,  1'b0);
    check("fwd_data2", bus.fwd_data2, 32'd0);
    cycle();
    bus.wstall = 1'b0;
    #1;
    check("x7_first",      bus.wdata,    32'hA);
    check("x7_head_hit",   bus.fwd_hit1, 1'b1);
    cycle();
    #1;
    check("x7_second", bus.wdata, 32'hB);
    cycle();
    idle();

    // Write to x0 is accepted and dropped.
    set_pipe(5'd0, 32'hdead);
    #1;
    check("x0_ready", bus.pipe_ready, 1'b1);
    check("x0_wren",  bus.wren,       1'b0);
    cycle();
    idle();
    #1;
    check("x0_after_wren", bus.wren, 1'b0);
    cycle();

    // Reset discards pending entries.
    bus.wstall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      set_pipe(5'(i), 32'h200 + 32'(i));
      cycle();
    end
    idle();
    rst = 1'b1;
    bus.fwd_addr1 = 5'd1;
    #1;
    check("rstmid_wren", bus.wren,     1'b0);
    check("rstmid_hit",  bus.fwd_hit1, 1'b0);
    cycle();
    rst = 1'b0;
    #1;
    check("rstrel_wren",  bus.wren,       1'b0);
    check("rstrel_ready", bus.pipe_ready, 1'b1);
    check("rstrel_hit",   bus.fwd_hit1,   1'b0);
    set_pipe(5'd9, 32'h99);
    #1;
`ifdef WBQ_BYPASS_EN
    check("x9_byp_wren",  bus.wren,  1'b1);
    check("x9_byp_waddr", bus.waddr, 5'd9);
`else
    check("x9_same_wren", bus.wren, 1'b0);
`endif
    cycle();
    idle();
`ifndef WBQ_BYPASS_EN
    #1;
    check("x9_waddr", bus.waddr, 5'd9);
`endif
    cycle();
    cycle();

    // Randomized traffic against the reference queue.
    for (int n = 0; n < 800; n++) begin
      rst            = ($urandom_range(0, 99) == 0);
      bus.pipe_valid = 1'($urandom_range(0, 1));
      bus.pipe_waddr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      bus.pipe_wdata = $urandom;
      bus.mdu_valid  = 1'($urandom_range(0, 1));
      bus.mdu_waddr  = 5'($urandom_range(0, 7));
      bus.mdu_wdata  = $urandom;
      bus.wstall     = ((n / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      bus.fwd_addr1  = 5'($urandom_range(0, 7));
      bus.fwd_addr2  = 5'($urandom_range(0, 7));
      cycle();
    end
    rst = 1'b0;
    idle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
